// File: rtl/m_col_seq.sv
// Start/done sequencer for one memristor column's reset, write, read, gnd and pre-charge lines.
// Define M_COL_SEQ_PROG_EN to add a cfg_* port for runtime-programmable phase timings.
module m_col_seq #(
    parameter int CNT_W = 8,
    parameter int T_RST = 25,
    parameter int T_GAP = 1,
    parameter int T_WR  = 10,
    parameter int T_PRE = 1,
    parameter int T_RD  = 15,
    parameter int T_REC = 14
) (
    input  logic             clk,
    input  logic             rst,
`ifdef M_COL_SEQ_PROG_EN
    input  logic             cfg_we,
    input  logic [2:0]       cfg_addr,
    input  logic [CNT_W-1:0] cfg_wdata,
`endif
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [3:0]       n_reads,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             sample,
    output logic [3:0]       read_idx,
    output logic             rst_ctrl,
    output logic             write1_ctrl,
    output logic             write2_ctrl,
    output logic             read1_ctrl,
    output logic             read2_ctrl,
    output logic             gnd_ctrl,
    output logic             pre_charge_ctrl
);

    typedef enum logic [3:0] {
        S_IDLE, S_RST, S_GAP1, S_WRITE, S_GAP2, S_PRE, S_READ, S_RECOV, S_DONE
    } state_t;

    localparam logic [1:0]       OP_FULL  = 2'b00;
    localparam logic [1:0]       OP_WRITE = 2'b01;
    localparam logic [1:0]       OP_BAD   = 2'b11;
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    state_t           state;
    state_t           nxt_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] nxt_cnt;
    logic [3:0]       nxt_idx;
    logic [1:0]       op_q;
    logic [3:0]       last_idx_q;
    logic             nxt_err;
    logic             accept;

    logic [CNT_W-1:0] t_rst_v;
    logic [CNT_W-1:0] t_gap_v;
    logic [CNT_W-1:0] t_wr_v;
    logic [CNT_W-1:0] t_pre_v;
    logic [CNT_W-1:0] t_rd_v;
    logic [CNT_W-1:0] t_rec_v;

`ifdef M_COL_SEQ_PROG_EN
    // Timing registers only change while idle, so a running sequence never sees a new value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_rst_v <= CNT_W'(T_RST);
            t_gap_v <= CNT_W'(T_GAP);
            t_wr_v  <= CNT_W'(T_WR);
            t_pre_v <= CNT_W'(T_PRE);
            t_rd_v  <= CNT_W'(T_RD);
            t_rec_v <= CNT_W'(T_REC);
        end else if (cfg_we && !busy) begin
            case (cfg_addr)
                3'd0:    t_rst_v <= cfg_wdata;
                3'd1:    t_gap_v <= cfg_wdata;
                3'd2:    t_wr_v  <= cfg_wdata;
                3'd3:    t_pre_v <= cfg_wdata;
                3'd4:    t_rd_v  <= cfg_wdata;
                3'd5:    t_rec_v <= cfg_wdata;
                default: ;
            endcase
        end
    end
`else
    assign t_rst_v = CNT_W'(T_RST);
    assign t_gap_v = CNT_W'(T_GAP);
    assign t_wr_v  = CNT_W'(T_WR);
    assign t_pre_v = CNT_W'(T_PRE);
    assign t_rd_v  = CNT_W'(T_RD);
    assign t_rec_v = CNT_W'(T_REC);
`endif

    // A zero timing still gives the phase one cycle.
    function automatic logic [CNT_W-1:0] load_of(input logic [CNT_W-1:0] t);
        load_of = (t == '0) ? '0 : t - ONE;
    endfunction

    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_idx   = read_idx;
        nxt_err   = 1'b0;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (op == OP_BAD) begin
                        nxt_err = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        nxt_idx = '0;
                        case (op)
                            OP_FULL: begin
                                nxt_state = S_RST;
                                nxt_cnt   = load_of(t_rst_v);
                            end
                            OP_WRITE: begin
                                nxt_state = S_WRITE;
                                nxt_cnt   = load_of(t_wr_v);
                            end
                            default: begin
                                nxt_state = S_PRE;
                                nxt_cnt   = load_of(t_pre_v);
                            end
                        endcase
                    end
                end
            end
            S_DONE: begin
                nxt_state = S_IDLE;
                nxt_cnt   = '0;
            end
            default: begin
                if (cnt != '0) begin
                    nxt_cnt = cnt - ONE;
                end else begin
                    case (state)
                        S_RST: begin
                            nxt_state = S_GAP1;
                            nxt_cnt   = load_of(t_gap_v);
                        end
                        S_GAP1: begin
                            nxt_state = S_WRITE;
                            nxt_cnt   = load_of(t_wr_v);
                        end
                        S_WRITE: begin
                            nxt_state = S_GAP2;
                            nxt_cnt   = load_of(t_gap_v);
                        end
                        S_GAP2: begin
                            if (op_q == OP_FULL) begin
                                nxt_state = S_PRE;
                                nxt_cnt   = load_of(t_pre_v);
                                nxt_idx   = '0;
                            end else begin
                                nxt_state = S_DONE;
                                nxt_cnt   = '0;
                            end
                        end
                        S_PRE: begin
                            nxt_state = S_READ;
                            nxt_cnt   = load_of(t_rd_v);
                        end
                        S_READ: begin
                            nxt_state = S_RECOV;
                            nxt_cnt   = load_of(t_rec_v);
                        end
                        S_RECOV: begin
                            if (read_idx == last_idx_q) begin
                                nxt_state = S_DONE;
                                nxt_cnt   = '0;
                            end else begin
                                nxt_state = S_PRE;
                                nxt_cnt   = load_of(t_pre_v);
                                nxt_idx   = read_idx + 4'd1;
                            end
                        end
                        default: begin
                            nxt_state = S_IDLE;
                            nxt_cnt   = '0;
                        end
                    endcase
                end
            end
        endcase
        // Abort overrides every transition except a start accepted from idle.
        if (abort && state != S_IDLE) begin
            nxt_state = S_IDLE;
            nxt_cnt   = '0;
            nxt_idx   = '0;
        end
    end

    // Outputs are decoded from the next state so each phase's lines change on its entry edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            cnt             <= '0;
            read_idx        <= '0;
            op_q            <= '0;
            last_idx_q      <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            err             <= 1'b0;
            sample          <= 1'b0;
            rst_ctrl        <= 1'b0;
            write1_ctrl     <= 1'b0;
            write2_ctrl     <= 1'b0;
            read1_ctrl      <= 1'b0;
            read2_ctrl      <= 1'b0;
            gnd_ctrl        <= 1'b1;
            pre_charge_ctrl <= 1'b1;
        end else begin
            state    <= nxt_state;
            cnt      <= nxt_cnt;
            read_idx <= nxt_idx;
            if (accept) begin
                op_q       <= op;
                last_idx_q <= (n_reads == 4'd0) ? 4'd0 : n_reads - 4'd1;
            end
            busy            <= (nxt_state != S_IDLE);
            done            <= (nxt_state == S_DONE);
            err             <= nxt_err;
            sample          <= (nxt_state == S_READ) && (nxt_cnt == '0);
            rst_ctrl        <= (nxt_state == S_RST);
            write1_ctrl     <= (nxt_state == S_WRITE);
            write2_ctrl     <= (nxt_state == S_WRITE);
            read1_ctrl      <= (nxt_state == S_READ);
            read2_ctrl      <= (nxt_state == S_READ);
            gnd_ctrl        <= !(nxt_state == S_PRE || nxt_state == S_READ || nxt_state == S_RECOV);
            pre_charge_ctrl <= (nxt_state != S_PRE);
        end
    end

endmodule

// File: tb/tb_m_col_seq.sv
// Testbench for m_col_seq: count-based vector table, cycle-exact phase-list model runs,
// reset/abort corner sequences and (with M_COL_SEQ_PROG_EN) runtime timing programming.
module tb_m_col_seq;

    typedef logic [14:0] vec_t;

    typedef struct {
        logic [1:0] op;
        logic [3:0] nr;
        int busyC;
        int rstC;
        int wrC;
        int rdC;
        int preC;
        int gndC;
        int smpC;
        int doneC;
        int errC;
    } row_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] op;
    logic [3:0] n_reads;
    logic       abort;
    logic       busy, done, err, sample;
    logic [3:0] read_idx;
    logic       rst_ctrl, write1_ctrl, write2_ctrl, read1_ctrl, read2_ctrl;
    logic       gnd_ctrl, pre_charge_ctrl;
`ifdef M_COL_SEQ_PROG_EN
    logic       cfg_we;
    logic [2:0] cfg_addr;
    logic [7:0] cfg_wdata;
    bit         busyCfg;
`endif

    int   checks;
    int   failures;
    int   tm[6];
    logic [3:0] lastIdx;
    vec_t expQ[$];
    row_t rows[7];

    m_col_seq dut (
        .clk(clk),
        .rst(rst),
`ifdef M_COL_SEQ_PROG_EN
        .cfg_we(cfg_we),
        .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata),
`endif
        .start(start),
        .op(op),
        .n_reads(n_reads),
        .abort(abort),
        .busy(busy),
        .done(done),
        .err(err),
        .sample(sample),
        .read_idx(read_idx),
        .rst_ctrl(rst_ctrl),
        .write1_ctrl(write1_ctrl),
        .write2_ctrl(write2_ctrl),
        .read1_ctrl(read1_ctrl),
        .read2_ctrl(read2_ctrl),
        .gnd_ctrl(gnd_ctrl),
        .pre_charge_ctrl(pre_charge_ctrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t pk(bit b, bit d, bit e, bit s, logic [3:0] idx,
                                bit r, bit w, bit rd, bit g, bit p);
        return {b, d, e, s, idx, r, w, w, rd, rd, g, p};
    endfunction

    function automatic vec_t dutVec();
        return {busy, done, err, sample, read_idx, rst_ctrl, write1_ctrl, write2_ctrl,
                read1_ctrl, read2_ctrl, gnd_ctrl, pre_charge_ctrl};
    endfunction

    task automatic applyStimulus(input bit s, input logic [1:0] o, input logic [3:0] n, input bit a);
        start   = s;
        op      = o;
        n_reads = n;
        abort   = a;
    endtask

    task automatic checkOutput(input string name, input int cyc, input vec_t exp);
        vec_t got;
        got = dutVec();
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s cycle %0d: got %b expected %b", name, cyc, got, exp);
        end
    endtask

    task automatic checkCount(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Expands the requested operation into its per-cycle list of expected output vectors.
    task automatic buildModel(input int opv, input int nr);
        int reads;
        int e[6];
        expQ.delete();
        reads = (nr == 0) ? 1 : nr;
        for (int i = 0; i < 6; i++) e[i] = (tm[i] == 0) ? 1 : tm[i];
        if (opv == 3) begin
            expQ.push_back(pk(0, 0, 1, 0, lastIdx, 0, 0, 0, 1, 1));
            return;
        end
        if (opv == 0) begin
            repeat (e[0]) expQ.push_back(pk(1, 0, 0, 0, 4'd0, 1, 0, 0, 1, 1));
            repeat (e[1]) expQ.push_back(pk(1, 0, 0, 0, 4'd0, 0, 0, 0, 1, 1));
        end
        if (opv != 2) begin
            repeat (e[2]) expQ.push_back(pk(1, 0, 0, 0, 4'd0, 0, 1, 0, 1, 1));
            repeat (e[1]) expQ.push_back(pk(1, 0, 0, 0, 4'd0, 0, 0, 0, 1, 1));
        end
        lastIdx = 4'd0;
        if (opv != 1) begin
            for (int r = 0; r < reads; r++) begin
                repeat (e[3]) expQ.push_back(pk(1, 0, 0, 0, 4'(r), 0, 0, 0, 0, 0));
                for (int c = 0; c < e[4]; c++)
                    expQ.push_back(pk(1, 0, 0, c == e[4] - 1, 4'(r), 0, 0, 1, 0, 1));
                repeat (e[5]) expQ.push_back(pk(1, 0, 0, 0, 4'(r), 0, 0, 0, 0, 1));
            end
            lastIdx = 4'(reads - 1);
        end
        expQ.push_back(pk(1, 1, 0, 0, lastIdx, 0, 0, 0, 1, 1));
    endtask

    // Called at a negedge; starts the run immediately and ends at a negedge in idle.
    task automatic runModel(input string name, input logic [1:0] opv, input logic [3:0] nr,
                            input bit noise, input bit abortToo);
        applyStimulus(1, opv, nr, abortToo);
        buildModel(opv, nr);
        for (int i = 0; i < expQ.size(); i++) begin
            @(negedge clk);
            checkOutput(name, i, expQ[i]);
            if (noise && expQ[i][14])
                applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                              4'($urandom_range(0, 15)), 0);
            else
                applyStimulus(0, 2'd0, 4'd0, 0);
`ifdef M_COL_SEQ_PROG_EN
            if (busyCfg && i == 1) begin
                cfg_we    = 1'b1;
                cfg_addr  = 3'd4;
                cfg_wdata = 8'd9;
            end else begin
                cfg_we = 1'b0;
            end
`endif
        end
        @(negedge clk);
        checkOutput({name, "_idle"}, expQ.size(), pk(0, 0, 0, 0, lastIdx, 0, 0, 0, 1, 1));
        applyStimulus(0, 2'd0, 4'd0, 0);
    endtask

    // Counts how long each line is active over a fixed window after one start.
    task automatic countRun(input int k);
        int c[9];
        for (int j = 0; j < 9; j++) c[j] = 0;
        applyStimulus(1, rows[k].op, rows[k].nr, 0);
        buildModel(int'(rows[k].op), int'(rows[k].nr));
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            applyStimulus(0, 2'd0, 4'd0, 0);
            c[0] += int'(busy);
            c[1] += int'(rst_ctrl);
            c[2] += int'(write1_ctrl && write2_ctrl);
            c[3] += int'(read1_ctrl && read2_ctrl);
            c[4] += int'(!pre_charge_ctrl);
            c[5] += int'(!gnd_ctrl);
            c[6] += int'(sample);
            c[7] += int'(done);
            c[8] += int'(err);
        end
        checkCount($sformatf("row%0d_busy", k), c[0], rows[k].busyC);
        checkCount($sformatf("row%0d_rst", k), c[1], rows[k].rstC);
        checkCount($sformatf("row%0d_write", k), c[2], rows[k].wrC);
        checkCount($sformatf("row%0d_read", k), c[3], rows[k].rdC);
        checkCount($sformatf("row%0d_pre", k), c[4], rows[k].preC);
        checkCount($sformatf("row%0d_gndlow", k), c[5], rows[k].gndC);
        checkCount($sformatf("row%0d_sample", k), c[6], rows[k].smpC);
        checkCount($sformatf("row%0d_done", k), c[7], rows[k].doneC);
        checkCount($sformatf("row%0d_err", k), c[8], rows[k].errC);
    endtask

`ifdef M_COL_SEQ_PROG_EN
    task automatic cfgWrite(input logic [2:0] a, input logic [7:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        @(negedge clk);
        cfg_we = 1'b0;
        if (a < 3'd6) tm[a] = int'(d);
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        tm       = '{25, 1, 10, 1, 15, 14};
        lastIdx  = 4'd0;
        rows[0] = '{2'd0, 4'd2,  98, 25, 10,  30,  2,  60,  2, 1, 0};
        rows[1] = '{2'd0, 4'd0,  68, 25, 10,  15,  1,  30,  1, 1, 0};
        rows[2] = '{2'd2, 4'd0,  31,  0,  0,  15,  1,  30,  1, 1, 0};
        rows[3] = '{2'd2, 4'd3,  91,  0,  0,  45,  3,  90,  3, 1, 0};
        rows[4] = '{2'd1, 4'd5,  12,  0, 10,   0,  0,   0,  0, 1, 0};
        rows[5] = '{2'd3, 4'd2,   0,  0,  0,   0,  0,   0,  0, 0, 1};
        rows[6] = '{2'd2, 4'd15, 451, 0,  0, 225, 15, 450, 15, 1, 0};
`ifdef M_COL_SEQ_PROG_EN
        cfg_we    = 1'b0;
        cfg_addr  = 3'd0;
        cfg_wdata = 8'd0;
        busyCfg   = 1'b0;
`endif
        rst = 1'b1;
        applyStimulus(0, 2'd0, 4'd0, 0);
        repeat (2) @(negedge clk);
        checkOutput("reset", 0, pk(0, 0, 0, 0, 4'd0, 0, 0, 0, 1, 1));
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_after_reset", 0, pk(0, 0, 0, 0, 4'd0, 0, 0, 0, 1, 1));

        runModel("full_n2", 2'd0, 4'd2, 0, 0);
        for (int k = 0; k < 7; k++) countRun(k);
        runModel("write_busy_starts", 2'd1, 4'd0, 1, 0);
        runModel("err_op3", 2'd3, 4'd5, 0, 0);
        runModel("start_with_abort", 2'd1, 4'd3, 0, 1);

        // Asynchronous reset in the middle of the WRITE phase of a FULL run.
        applyStimulus(1, 2'd0, 4'd2, 0);
        buildModel(0, 2);
        for (int i = 0; i <= 30; i++) begin
            @(negedge clk);
            applyStimulus(0, 2'd0, 4'd0, 0);
            checkOutput("pre_rst", i, expQ[i]);
        end
        #1 rst = 1'b1;
        #1 checkOutput("mid_run_rst", 30, pk(0, 0, 0, 0, 4'd0, 0, 0, 0, 1, 1));
        lastIdx = 4'd0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Abort during the first READ window, then an immediate new start.
        applyStimulus(1, 2'd0, 4'd2, 0);
        buildModel(0, 2);
        for (int i = 0; i <= 40; i++) begin
            @(negedge clk);
            checkOutput("pre_abort", i, expQ[i]);
            applyStimulus(0, 2'd0, 4'd0, i == 40);
        end
        @(negedge clk);
        lastIdx = 4'd0;
        checkOutput("abort_idle", 41, pk(0, 0, 0, 0, 4'd0, 0, 0, 0, 1, 1));
        runModel("after_abort", 2'd2, 4'd1, 0, 0);

        for (int r = 0; r < 8; r++)
            runModel($sformatf("rand%0d", r), 2'($urandom_range(0, 3)),
                     4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 0);

`ifdef M_COL_SEQ_PROG_EN
        cfgWrite(3'd4, 8'd3);
        cfgWrite(3'd5, 8'd2);
        cfgWrite(3'd6, 8'd99);
        runModel("prog_rd3", 2'd2, 4'd1, 0, 0);
        busyCfg = 1'b1;
        runModel("prog_busy_write", 2'd2, 4'd1, 0, 0);
        busyCfg = 1'b0;
        runModel("prog_after_busy", 2'd2, 4'd1, 0, 0);
        cfgWrite(3'd3, 8'd0);
        runModel("prog_tpre0", 2'd2, 4'd2, 0, 0);
        runModel("prog_full", 2'd0, 4'd2, 0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
